prog_loader: RTL and testbench

- Writer side of the processor's instruction-memory interface. The processor only reads instruction RAM; this block fills it.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction RAM at word-aligned byte addresses, the same addressing the PC uses.
- Holds the processor in reset until a complete image has arrived and its checksum is correct.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_byte_packer.sv | 57 +++++
 rtl/prog_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_pkg
// Purpose : Shared types and constants for the instruction-memory loader.
//           Holds the loader state encoding and the instruction word width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int INST_WORD_W = 32;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_byte_packer
// Purpose : Packs a byte stream into big-endian instruction words. The first
//           byte of each group of four lands in the most significant byte.
// Ports   : clk, reset (async, active-low)
//           clear      - synchronous clear of the shift register and index
//           byte_valid - a byte is accepted this cycle
//           byte_data  - the accepted byte
//           word_valid - one-cycle strobe, fourth byte of a word accepted
//           word_data  - the completed word (valid with word_valid)
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   word_valid,
  output logic [INST_WORD_W-1:0] word_data
);

  logic [INST_WORD_W-1:0] shift_q, shift_d;
  logic [1:0]             byte_idx_q, byte_idx_d;

  always_comb begin
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      shift_d    = '0;
      byte_idx_d = 2'd0;
    end else if (byte_valid) begin
      shift_d    = {shift_q[INST_WORD_W-9:0], byte_data};
      byte_idx_d = byte_idx_q + 2'd1;  // wraps 3 -> 0 at each word boundary
    end
  end

  // The completed word is presented combinationally alongside the fourth
  // byte so the parent can register the RAM write with no extra stall.
  assign word_valid = byte_valid && !clear && (byte_idx_q == 2'd3);
  assign word_data  = {shift_q[INST_WORD_W-9:0], byte_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      byte_idx_q <= 2'd0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule : prog_loader_byte_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Purpose : Writer side of the instruction RAM. Receives an image as a byte
//           stream (16-bit word count, big-endian words, XOR checksum byte),
//           writes each word at its word-aligned byte address and keeps the
//           CPU in reset until a complete image with a good checksum lands.
// Ports   : clk, reset (async, active-low), start (re-arm from DONE/ERR)
//           in_valid/in_data/in_ready - byte stream handshake
//           ram_we/ram_addr/ram_wdata - instruction RAM write port
//           cpu_hold, done, err       - status
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   ram_we,
  output logic [31:0]            ram_addr,
  output logic [INST_WORD_W-1:0] ram_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  // Largest legal image, in words, sized wide enough to hold 2^ADDR_W.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_e                 state_q, state_d;
  logic [15:0]            count_q, count_d;
  // One extra bit so a full-depth image counts up to 2^ADDR_W without wrap.
  logic [ADDR_W:0]        word_idx_q, word_idx_d, word_idx_nxt;
  logic [7:0]             csum_q, csum_d;
  logic                   in_ready_q, in_ready_d;
  logic                   ram_we_q, ram_we_d;
  logic [31:0]            ram_addr_q, ram_addr_d;
  logic [INST_WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   pack_valid;
  logic                   pack_clear;
  logic                   word_valid;
  logic [INST_WORD_W-1:0] word_data;

  assign accept       = in_valid && in_ready_q;
  assign pack_valid   = accept && (state_q == S_DATA);
  assign word_idx_nxt = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    pack_clear  = 1'b0;

    case (state_q)
      S_CNT_HI: begin
        if (accept) begin
          count_d = {in_data, count_q[7:0]};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], in_data};
          if ({1'b0, count_d} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (count_d == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
        end
        if (word_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = 32'({word_idx_q[ADDR_W-1:0], 2'b00});
          ram_wdata_d = word_data;
          word_idx_d  = word_idx_nxt;
          if (17'(word_idx_nxt) == {1'b0, count_q}) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_CNT_HI;
          count_d    = 16'd0;
          word_idx_d = '0;
          csum_d     = 8'd0;
          pack_clear = 1'b1;
        end
      end
      default: state_d = S_CNT_HI;
    endcase

    // Status outputs are derived from the next state so they register in
    // lockstep with the state itself.
    in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CNT_HI;
      count_q     <= 16'd0;
      word_idx_q  <= '0;
      csum_q      <= 8'd0;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_loader
// Purpose : Self-checking bench for prog_loader. Expected RAM writes are
//           queued as images are sent; a negedge monitor pops and compares
//           every ram_we pulse. Status outputs are checked after each image.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'd0;
  logic        in_ready;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] img [0:255];
  int          gap_tbl [0:7] = '{0, 2, 3, 0, 1, 0, 1, 4};

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every ram_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (ram_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 ram_addr, ram_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("write_addr", ram_addr, e[63:32]);
        chk("write_data", ram_wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", t);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input logic [7:0] cs, input bit gaps);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
    for (int w = 0; w < n; w++) begin
      sb_q.push_back({32'(w << 2), img[w]});
      for (int k = 0; k < 4; k++) begin
        send_byte(img[w][31-8*k -: 8], gaps ? gap_tbl[(4*w+k) % 8] : 0);
      end
    end
    send_byte(cs, 0);
    idle();
  endtask

  task automatic check_status(input string p, input logic rdy, input logic dn,
                              input logic er, input logic hold);
    chk({p, "_in_ready"}, in_ready, rdy);
    chk({p, "_done"},     done,     dn);
    chk({p, "_err"},      err,      er);
    chk({p, "_cpu_hold"}, cpu_hold, hold);
  endtask

  task automatic check_reset_values(input string p);
    check_status(p, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({p, "_ram_we"},    ram_we,    0);
    chk({p, "_ram_addr"},  ram_addr,  0);
    chk({p, "_ram_wdata"}, ram_wdata, 0);
  endtask

  task automatic pulse_start(input string p);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status(p, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_image_a();
    img[0] = 32'h8C010004;
    img[1] = 32'h00221820;
  endtask

  initial begin
    // Reset state, then in_ready rises on the first edge after release.
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 1'b1);

    // Good two-word image.
    set_image_a();
    send_image(2, 8'h93, 1'b0);
    check_status("imgA", 1'b0, 1'b1, 1'b0, 1'b0);

    // Same image, corrupted checksum.
    pulse_start("rearm1");
    send_image(2, 8'h92, 1'b0);
    check_status("badcs", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start("rearm2");

    // Oversized header: error right after count_lo, no writes.
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    idle();
    check_status("toobig", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start("rearm3");

    // Empty image with good and bad checksum.
    send_image(0, 8'h00, 1'b0);
    check_status("n0_ok", 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start("rearm4");
    send_image(0, 8'h5A, 1'b0);
    check_status("n0_bad", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start("rearm5");

    // Three words with valid gaps, including one before the third byte.
    img[0] = 32'h11223344;
    img[1] = 32'hA5A5005A;
    img[2] = 32'hDEADBEEF;
    send_image(3, 8'h3C, 1'b1);
    check_status("gaps", 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start("rearm6");

    // Full-depth image: last address 0x3FC, word index must not wrap.
    // Each word's bytes XOR to zero across the image, so checksum is 0x00.
    for (int i = 0; i < 256; i++) begin
      img[i] = {8'hC3, 8'(i), ~8'(i), 8'h5A};
    end
    send_image(256, 8'h00, 1'b0);
    check_status("full", 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start("rearm7");

    // Reset after five payload bytes: first word written, then abort.
    set_image_a();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    sb_q.push_back({32'h0, img[0]});
    for (int k = 0; k < 4; k++) send_byte(img[0][31-8*k -: 8], 0);
    send_byte(img[1][31:24], 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_status("midrst_rel", 1'b1, 1'b0, 1'b0, 1'b1);
    send_image(2, 8'h93, 1'b0);
    check_status("reload", 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_prog_loader
`default_nettype wire
